// File: rtl/avalon_multichannel_timer_if.sv
// Avalon-MM slave bus bundle for the multichannel timer: address, strobes and 32-bit data paths.
`timescale 1ns/1ps
interface avalon_multichannel_timer_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (output address, chipselect, read, write, writedata, input readdata);
   modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/avalon_multichannel_timer.sv
// N-channel interval timer behind an Avalon-MM slave; shared prescaler, per-channel period,
// mode, snapshot and timeout interrupt, plus a combined irq line.
`timescale 1ns/1ps
module avalon_multichannel_timer #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 32,
   parameter int PRESCALE     = 1,
   parameter int RESET_PERIOD = 49999
) (
   input  logic                       clk,
   input  logic                       reset,
   avalon_multichannel_timer_if.slave bus,
   output logic                       irq,
   output logic [N_CH-1:0]            irq_vec
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

   logic [PS_W-1:0]  ps;
   logic             tick;
   logic [CH_W-1:0]  ch_idx;
   logic [1:0]       reg_sel;
   logic             ch_ok;
   logic             wr;
   logic             rd;
   logic [31:0]      rd_val;

   logic [CNT_W-1:0] cnt    [N_CH];
   logic [CNT_W-1:0] period [N_CH];
   logic [CNT_W-1:0] snap   [N_CH];
   logic [N_CH-1:0]  ito;
   logic [N_CH-1:0]  cont;
   logic [N_CH-1:0]  to;
   logic [N_CH-1:0]  run;
   logic [N_CH-1:0]  reload_pend;
   logic [N_CH-1:0]  wr_status;
   logic [N_CH-1:0]  wr_ctrl;
   logic [N_CH-1:0]  wr_period;
   logic [N_CH-1:0]  wr_snap;
   logic [N_CH-1:0]  expire;

   assign tick    = (ps == PS_W'(PRESCALE - 1));
   assign ch_idx  = CH_W'(bus.address >> 2);
   assign reg_sel = bus.address[1:0];
   assign ch_ok   = (int'(ch_idx) < N_CH);
   assign wr      = bus.chipselect & bus.write & ch_ok;
   assign rd      = bus.chipselect & bus.read;

   assign irq_vec = to & ito;
   assign irq     = |irq_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         ps <= '0;
      end else if (tick) begin
         ps <= '0;
      end else begin
         ps <= ps + 1'b1;
      end
   end

   // expire excludes the force-reload cycle so a reload never doubles as a timeout
   always_comb begin
      wr_status = '0;
      wr_ctrl   = '0;
      wr_period = '0;
      wr_snap   = '0;
      expire    = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         wr_status[ch] = wr && (ch_idx == CH_W'(ch)) && (reg_sel == 2'd0);
         wr_ctrl[ch]   = wr && (ch_idx == CH_W'(ch)) && (reg_sel == 2'd1);
         wr_period[ch] = wr && (ch_idx == CH_W'(ch)) && (reg_sel == 2'd2);
         wr_snap[ch]   = wr && (ch_idx == CH_W'(ch)) && (reg_sel == 2'd3);
         expire[ch]    = tick && run[ch] && !reload_pend[ch] && (cnt[ch] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            cnt[ch]    <= RST_VAL;
            period[ch] <= RST_VAL;
            snap[ch]   <= '0;
         end
         ito         <= '0;
         cont        <= '0;
         to          <= '0;
         run         <= '0;
         reload_pend <= '0;
      end else begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (wr_period[ch]) period[ch] <= bus.writedata[CNT_W-1:0];
            reload_pend[ch] <= wr_period[ch];

            if (wr_ctrl[ch]) begin
               ito[ch]  <= bus.writedata[0];
               cont[ch] <= bus.writedata[1];
            end

            if (wr_snap[ch]) snap[ch] <= cnt[ch];

            if (reload_pend[ch]) begin
               cnt[ch] <= period[ch];
            end else if (expire[ch]) begin
               cnt[ch] <= wr_period[ch] ? bus.writedata[CNT_W-1:0] : period[ch];
            end else if (tick && run[ch]) begin
               cnt[ch] <= cnt[ch] - 1'b1;
            end

            if (expire[ch]) begin
               to[ch] <= 1'b1;
            end else if (wr_status[ch]) begin
               to[ch] <= 1'b0;
            end

            // STOP and a pending reload both override START
            if (reload_pend[ch] || (wr_ctrl[ch] && bus.writedata[3])) begin
               run[ch] <= 1'b0;
            end else if (wr_ctrl[ch] && bus.writedata[2]) begin
               run[ch] <= 1'b1;
            end else if (expire[ch]) begin
               run[ch] <= cont[ch] & ~wr_period[ch];
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (ch_idx == CH_W'(ch)) begin
            case (reg_sel)
               2'd0:    rd_val = {30'b0, run[ch], to[ch]};
               2'd1:    rd_val = {30'b0, cont[ch], ito[ch]};
               2'd2:    rd_val = 32'(period[ch]);
               default: rd_val = 32'(snap[ch]);
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.readdata <= '0;
      end else if (rd) begin
         bus.readdata <= rd_val;
      end
   end
endmodule

// File: tb/tb_avalon_multichannel_timer.sv
// Bench for avalon_multichannel_timer: one 3-channel 16-bit instance ticking every cycle and
// one 4-channel 32-bit instance with a prescale of 4.
`timescale 1ns/1ps
module tb_avalon_multichannel_timer;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avalon_multichannel_timer_if #(.ADDR_W(4)) bus_a ();
   avalon_multichannel_timer_if #(.ADDR_W(4)) bus_b ();
   logic       irq_a;
   logic [2:0] irq_vec_a;
   logic       irq_b;
   logic [3:0] irq_vec_b;

   avalon_multichannel_timer #(.N_CH(3), .CNT_W(16), .PRESCALE(1), .RESET_PERIOD(49999)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .irq(irq_a), .irq_vec(irq_vec_a));
   avalon_multichannel_timer #(.N_CH(4), .CNT_W(32), .PRESCALE(4), .RESET_PERIOD(49999)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .irq(irq_b), .irq_vec(irq_vec_b));

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int          sel;
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive_idle();
      bus_a.chipselect = 1'b0; bus_a.read = 1'b0; bus_a.write = 1'b0;
      bus_a.address = '0; bus_a.writedata = '0;
      bus_b.chipselect = 1'b0; bus_b.read = 1'b0; bus_b.write = 1'b0;
      bus_b.address = '0; bus_b.writedata = '0;
   endtask

   task automatic bus_write(input int sel, input logic [3:0] addr, input logic [31:0] data);
      if (sel == 0) begin
         bus_a.address = addr; bus_a.writedata = data; bus_a.chipselect = 1'b1; bus_a.write = 1'b1;
      end else begin
         bus_b.address = addr; bus_b.writedata = data; bus_b.chipselect = 1'b1; bus_b.write = 1'b1;
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic bus_read(input int sel, input logic [3:0] addr, output logic [31:0] data);
      if (sel == 0) begin
         bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.read = 1'b1;
      end else begin
         bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.read = 1'b1;
      end
      @(posedge clk); #1;
      data = (sel == 0) ? bus_a.readdata : bus_b.readdata;
      drive_idle();
   endtask

   task automatic read_expect(input int sel, input logic [3:0] addr, input logic [31:0] exp,
                              input string name);
      logic [31:0] got;
      exp_t        e;
      sb.push_back('{name, exp});
      bus_read(sel, addr, got);
      e = sb.pop_front();
      check(e.name, got, e.exp);
   endtask

   task automatic wait_irq(input int sel, input int ch, input int budget, input string name,
                           output int at);
      bit seen;
      seen = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk); #1;
         if (sel == 0 ? irq_vec_a[ch] : irq_vec_b[ch]) begin
            seen = 1'b1;
            at = cyc;
         end
      end
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        v[18];
      int          t0, t1, t2;
      logic [31:0] s;

      // Register-level vectors: reset values, width masking, unmapped channel, strobes.
      v[0]  = '{0, 1'b0, 4'h0, 32'h0,        32'h0,        "a_ch0_status_rst"};
      v[1]  = '{0, 1'b0, 4'h1, 32'h0,        32'h0,        "a_ch0_ctrl_rst"};
      v[2]  = '{0, 1'b0, 4'h2, 32'h0,        32'd49999,    "a_ch0_period_rst"};
      v[3]  = '{0, 1'b0, 4'h3, 32'h0,        32'h0,        "a_ch0_snap_rst"};
      v[4]  = '{0, 1'b0, 4'hA, 32'h0,        32'd49999,    "a_ch2_period_rst"};
      v[5]  = '{1, 1'b0, 4'hE, 32'h0,        32'd49999,    "b_ch3_period_rst"};
      v[6]  = '{0, 1'b1, 4'h6, 32'h1234ABCD, 32'h0,        ""};
      v[7]  = '{0, 1'b0, 4'h6, 32'h0,        32'h0000ABCD, "a_ch1_period_trunc"};
      v[8]  = '{1, 1'b1, 4'h6, 32'h1234ABCD, 32'h0,        ""};
      v[9]  = '{1, 1'b0, 4'h6, 32'h0,        32'h1234ABCD, "b_ch1_period_full"};
      v[10] = '{0, 1'b1, 4'hE, 32'd5,        32'h0,        ""};
      v[11] = '{0, 1'b0, 4'hE, 32'h0,        32'h0,        "a_ch3_read_zero"};
      v[12] = '{0, 1'b1, 4'h5, 32'h3,        32'h0,        ""};
      v[13] = '{0, 1'b0, 4'h5, 32'h0,        32'h3,        "a_ch1_ctrl_rd"};
      v[14] = '{0, 1'b1, 4'h5, 32'hF,        32'h0,        ""};
      v[15] = '{0, 1'b0, 4'h4, 32'h0,        32'h0,        "a_ch1_startstop_run"};
      v[16] = '{0, 1'b0, 4'h5, 32'h0,        32'h3,        "a_ch1_ctrl_strobes_zero"};
      v[17] = '{0, 1'b1, 4'h5, 32'h0,        32'h0,        ""};

      drive_idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_readdata_a", bus_a.readdata, 32'h0);
      check("rst_readdata_b", bus_b.readdata, 32'h0);
      check("rst_irq_a", 32'(irq_a), 32'h0);
      check("rst_irq_vec_a", 32'(irq_vec_a), 32'h0);
      check("rst_irq_b", 32'(irq_b), 32'h0);
      check("rst_irq_vec_b", 32'(irq_vec_b), 32'h0);

      for (int i = 0; i < 18; i++) begin
         if (v[i].wr) bus_write(v[i].sel, v[i].addr, v[i].data);
         else read_expect(v[i].sel, v[i].addr, v[i].exp, v[i].name);
      end

      // Continuous ch0, period 9: timeout every 10 clk; then status write colliding with a timeout.
      bus_write(0, 4'h2, 32'd9);
      bus_write(0, 4'h1, 32'h3);
      bus_write(0, 4'h1, 32'h7);
      t0 = cyc;
      wait_irq(0, 0, 40, "t1_first", t1);
      check("t1_first_latency", 32'(t1 - t0), 32'd10);
      repeat (3) @(posedge clk);
      #1 check("t1_irq_held", 32'(irq_a), 32'd1);
      bus_write(0, 4'h0, 32'h0);
      check("t1_irq_cleared", 32'(irq_a), 32'd0);
      wait_irq(0, 0, 40, "t1_second", t2);
      check("t1_period", 32'(t2 - t1), 32'd10);
      repeat (9) @(posedge clk);
      #1 bus_write(0, 4'h0, 32'h0);
      check("t4_irq_kept", 32'(irq_a), 32'd1);
      read_expect(0, 4'h0, 32'h3, "t4_status_to_run");
      bus_write(0, 4'h1, 32'h8);
      bus_write(0, 4'h0, 32'h0);
      check("t1_irq_after_stop", 32'(irq_a), 32'd0);

      // One-shot ch1, period 4.
      bus_write(0, 4'h6, 32'd4);
      bus_write(0, 4'h5, 32'h1);
      bus_write(0, 4'h5, 32'h5);
      t0 = cyc;
      wait_irq(0, 1, 40, "t2_oneshot", t1);
      check("t2_latency", 32'(t1 - t0), 32'd5);
      repeat (6) @(posedge clk);
      #1 read_expect(0, 4'h4, 32'h1, "t2_status_once");
      check("t2_irq_vec", 32'(irq_vec_a), 32'h2);
      bus_write(0, 4'h7, 32'h0);
      read_expect(0, 4'h7, 32'd4, "t2_counter_hold");
      bus_write(0, 4'h4, 32'h0);
      bus_write(0, 4'h5, 32'h0);

      // ch2: START+STOP, then PERIOD write while running.
      bus_write(0, 4'hA, 32'd100);
      bus_write(0, 4'h9, 32'h2);
      bus_write(0, 4'h9, 32'h6);
      read_expect(0, 4'h8, 32'h2, "t5_running");
      bus_write(0, 4'h9, 32'hE);
      read_expect(0, 4'h8, 32'h0, "t5_startstop");
      bus_write(0, 4'h9, 32'h6);
      read_expect(0, 4'h8, 32'h2, "t5_restart");
      bus_write(0, 4'hA, 32'd50);
      @(posedge clk);
      #1 read_expect(0, 4'h8, 32'h0, "t5_period_stops");
      bus_write(0, 4'hB, 32'h0);
      read_expect(0, 4'hB, 32'd50, "t5_counter_reloaded");

      // Prescaled instance, ch2 period 2: timeouts 12 clk apart, snapshots in 0..2.
      bus_write(1, 4'hA, 32'd2);
      bus_write(1, 4'h9, 32'h3);
      bus_write(1, 4'h9, 32'h7);
      wait_irq(1, 2, 60, "t3_first", t1);
      bus_write(1, 4'h8, 32'h0);
      wait_irq(1, 2, 60, "t3_second", t2);
      check("t3_period", 32'(t2 - t1), 32'd12);
      for (int i = 0; i < 4; i++) begin
         repeat (i + 1) @(posedge clk);
         #1 bus_write(1, 4'hB, 32'h0);
         bus_read(1, 4'hB, s);
         check("t3_snap_range", 32'(s <= 32'd2), 32'd1);
      end

      // Reset in the middle of activity on both instances.
      bus_write(0, 4'h2, 32'd9);
      bus_write(0, 4'h1, 32'h3);
      bus_write(0, 4'h1, 32'h7);
      read_expect(0, 4'h2, 32'd9, "t6_pre_period");
      wait_irq(0, 0, 40, "t6_pre_irq", t1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("t6_readdata_a", bus_a.readdata, 32'h0);
      check("t6_irq_a", 32'(irq_a), 32'h0);
      check("t6_irq_vec_b", 32'(irq_vec_b), 32'h0);
      read_expect(0, 4'h0, 32'h0, "t6_a_status");
      read_expect(0, 4'h1, 32'h0, "t6_a_ctrl");
      read_expect(0, 4'h2, 32'd49999, "t6_a_period");
      read_expect(0, 4'h3, 32'h0, "t6_a_snap");
      bus_write(0, 4'h3, 32'h0);
      read_expect(0, 4'h3, 32'd49999, "t6_a_counter");
      read_expect(1, 4'h8, 32'h0, "t6_b_status");
      read_expect(1, 4'hA, 32'd49999, "t6_b_period");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
